// File: rtl/fp_addsub_pipe_if.sv
// fp_addsub_pipe_if
// Handshake bundle for the pipelined floating-point adder/subtractor.
// Carries the operand beat (in_valid/in_ready, a, b, mode) from the FPU
// issue logic and the result beat (out_valid/out_ready, sum, flags) towards
// the writeback arbiter.
//   master modport : issue/writeback side (drives operands and out_ready)
//   slave modport  : the adder itself (drives in_ready and the result)
// flags = {invalid, overflow, inexact} for the value currently on sum.
interface fp_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [2:0]       flags;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, sum, flags
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, sum, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe
// Three-stage pipelined IEEE-754-style adder/subtractor (a + b or a - b).
//   S1: unpack, classify, resolve special operands, swap, align small operand
//   S2: add or subtract the aligned significands
//   S3: normalise, round, detect flush/overflow, pack into the output register
// Subnormal inputs are treated as zero and tiny results flush to signed zero.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears all valids and sum/flags
//   bus  - fp_addsub_pipe_if.slave: operand beat in, result beat out
// Build option:
//   FPU_ADDSUB_RNE_EN defined   -> round to nearest even, overflow gives +-inf
//   FPU_ADDSUB_RNE_EN undefined -> truncate, overflow gives +-max finite
module fp_addsub_pipe #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic            clk,
    input  logic            rst,
    fp_addsub_pipe_if.slave bus
);
    localparam int E   = EXP_WIDTH;
    localparam int M   = MAN_WIDTH;
    localparam int SW  = M + 4;
    localparam int XW  = E + 2;
    localparam int LZW = $clog2(M + 5);
    localparam logic [E-1:0]         EXP_ONES   = '1;
    localparam logic [E-1:0]         EXP_MAXFIN = EXP_ONES - 1'b1;
    localparam logic signed [XW-1:0] EXP_LIMIT  = {2'b00, EXP_ONES};

`ifdef FPU_ADDSUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // The whole pipe moves together; it only freezes when a finished
    // result is waiting on the output and downstream refuses it.
    logic adv;
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    logic             sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [E-1:0]     exp_a, exp_b, exp_big, exp_diff;
    logic [M-1:0]     frac_a, frac_b;
    logic             swap, sign_big, sign_small, lost;
    logic [SW-1:0]    sig_big, sig_small_raw, sig_small_shifted, sig_small;
    logic             special;
    logic [WIDTH-1:0] special_val;
    logic [2:0]       special_flags;

    // S1: classify operands, pick the larger magnitude, and right-align the
    // smaller significand into {1, frac, guard, round, sticky}. Any shift of
    // SW or more leaves only the sticky bit set, which the lost-bit OR covers.
    always_comb begin
        sign_a = bus.a[WIDTH-1];
        sign_b = bus.b[WIDTH-1] ^ bus.mode;
        exp_a  = bus.a[M +: E];
        exp_b  = bus.b[M +: E];
        frac_a = bus.a[M-1:0];
        frac_b = bus.b[M-1:0];
        zero_a = (exp_a == '0);
        zero_b = (exp_b == '0);
        inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
        inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
        nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
        nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);

        swap          = {exp_b, frac_b} > {exp_a, frac_a};
        exp_big       = swap ? exp_b : exp_a;
        exp_diff      = swap ? (exp_b - exp_a) : (exp_a - exp_b);
        sign_big      = swap ? sign_b : sign_a;
        sign_small    = swap ? sign_a : sign_b;
        sig_big       = {1'b1, (swap ? frac_b : frac_a), 3'b000};
        sig_small_raw = {1'b1, (swap ? frac_a : frac_b), 3'b000};
        sig_small_shifted = sig_small_raw >> exp_diff;
        lost      = |(sig_small_raw & ~({SW{1'b1}} << exp_diff));
        sig_small = {sig_small_shifted[SW-1:1], sig_small_shifted[0] | lost};

        special       = 1'b0;
        special_val   = '0;
        special_flags = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
            special       = 1'b1;
            special_val   = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
            special_flags = 3'b100;
        end else if (inf_a) begin
            special     = 1'b1;
            special_val = {sign_a, EXP_ONES, {M{1'b0}}};
        end else if (inf_b) begin
            special     = 1'b1;
            special_val = {sign_b, EXP_ONES, {M{1'b0}}};
        end else if (zero_a && zero_b) begin
            special     = 1'b1;
            special_val = {sign_a & sign_b, {(WIDTH-1){1'b0}}};
        end else if (zero_a) begin
            special     = 1'b1;
            special_val = {sign_b, exp_b, frac_b};
        end else if (zero_b) begin
            special     = 1'b1;
            special_val = {sign_a, exp_a, frac_a};
        end
    end

    logic             s1_valid, s1_special, s1_sign_big, s1_sign_small;
    logic [WIDTH-1:0] s1_special_val;
    logic [2:0]       s1_special_flags;
    logic [E-1:0]     s1_exp;
    logic [SW-1:0]    s1_big, s1_small;

    logic             s2_valid, s2_special, s2_sign;
    logic [WIDTH-1:0] s2_special_val;
    logic [2:0]       s2_special_flags;
    logic [E-1:0]     s2_exp;
    logic [SW:0]      s2_sig;

    // S2: magnitude add or subtract; big - small can never go negative.
    logic [SW:0] sig_sum;
    always_comb begin
        if (s1_sign_big ^ s1_sign_small)
            sig_sum = {1'b0, s1_big} - {1'b0, s1_small};
        else
            sig_sum = {1'b0, s1_big} + {1'b0, s1_small};
    end

    logic [LZW-1:0]       lzc;
    logic [SW-1:0]        norm;
    logic signed [XW-1:0] exp_norm, exp_round;
    logic [M:0]           mant;
    logic [M+1:0]         mant_round;
    logic [M-1:0]         frac_out;
    logic                 guard, round_bit, sticky, round_up;
    logic [WIDTH-1:0]     result;
    logic [2:0]           result_flags;

    // S3: normalise (carry-out shifts right, otherwise left by the leading
    // zero count), round, then pick between special, zero, flush, overflow
    // and the ordinary packed result.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < SW; i++) begin
            if (s2_sig[i]) lzc = LZW'(SW - 1 - i);
        end
        if (s2_sig[SW]) begin
            norm     = {s2_sig[SW:2], s2_sig[1] | s2_sig[0]};
            exp_norm = {2'b00, s2_exp} + XW'(1);
        end else begin
            norm     = s2_sig[SW-1:0] << lzc;
            exp_norm = {2'b00, s2_exp} - XW'(lzc);
        end
        mant       = norm[SW-1:3];
        guard      = norm[2];
        round_bit  = norm[1];
        sticky     = norm[0];
        round_up   = RNE && guard && (round_bit || sticky || mant[0]);
        mant_round = {1'b0, mant} + {{(M+1){1'b0}}, round_up};
        exp_round  = exp_norm + XW'(mant_round[M+1]);
        frac_out   = mant_round[M+1] ? mant_round[M:1] : mant_round[M-1:0];

        result       = {s2_sign, exp_round[E-1:0], frac_out};
        result_flags = {2'b00, guard | round_bit | sticky};
        if (s2_special) begin
            result       = s2_special_val;
            result_flags = s2_special_flags;
        end else if (s2_sig == '0) begin
            result       = '0;
            result_flags = '0;
        end else if (exp_norm <= 0) begin
            result       = {s2_sign, {(WIDTH-1){1'b0}}};
            result_flags = 3'b001;
        end else if (exp_round >= EXP_LIMIT) begin
            result       = RNE ? {s2_sign, EXP_ONES, {M{1'b0}}}
                               : {s2_sign, EXP_MAXFIN, {M{1'b1}}};
            result_flags = 3'b011;
        end
    end

    // Stage registers. Only valids and the visible output are reset; data
    // registers are don't-care while their valid is low. Bubbles leave the
    // last result on sum/flags untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.flags     <= '0;
        end else if (adv) begin
            s1_valid         <= bus.in_valid;
            s1_special       <= special;
            s1_special_val   <= special_val;
            s1_special_flags <= special_flags;
            s1_sign_big      <= sign_big;
            s1_sign_small    <= sign_small;
            s1_exp           <= exp_big;
            s1_big           <= sig_big;
            s1_small         <= sig_small;

            s2_valid         <= s1_valid;
            s2_special       <= s1_special;
            s2_special_val   <= s1_special_val;
            s2_special_flags <= s1_special_flags;
            s2_sign          <= s1_sign_big;
            s2_exp           <= s1_exp;
            s2_sig           <= sig_sum;

            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.sum   <= result;
                bus.flags <= result_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe
// Self-checking bench for fp_addsub_pipe (single-precision parameters).
// Directed cases from the design notes, a backpressure stream, a mid-flight
// reset and a randomized stream with random out_ready, all scored against an
// exact-integer reference model that rounds the true sum.
// Honours FPU_ADDSUB_RNE_EN the same way the design does.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_addsub_pipe_if #(.WIDTH(32)) bus ();

    fp_addsub_pipe #(
        .WIDTH(32),
        .EXP_WIDTH(8),
        .MAN_WIDTH(23)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef FPU_ADDSUB_RNE_EN
    localparam bit TB_RNE = 1'b1;
`else
    localparam bit TB_RNE = 1'b0;
`endif

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  flags;
    } expect_t;

    expect_t expQueue[$];
    int      checkCount = 0;
    int      errorCount = 0;
    bit      monitorOn  = 1'b0;
    bit      randomDone = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Exact reference: scale both significands onto one wide integer grid,
    // add/subtract exactly, then normalise and round the true result.
    function automatic void modelAddSub(input logic [31:0] av, input logic [31:0] bv,
                                        input logic mv, output logic [31:0] rs,
                                        output logic [2:0] rf);
        logic         sa, sb, rsign, inexact;
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic [299:0] ma, mb, mag, rem, half;
        logic [24:0]  mant;
        int           p, e, sh;
        sa = av[31];
        sb = bv[31] ^ mv;
        ea = av[30:23];
        eb = bv[30:23];
        fa = av[22:0];
        fb = bv[22:0];
        rs = '0;
        rf = '0;
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb)) begin
            rs = 32'h7FC00000;
            rf = 3'b100;
        end else if (ea == 8'hFF) begin
            rs = {sa, 8'hFF, 23'h0};
        end else if (eb == 8'hFF) begin
            rs = {sb, 8'hFF, 23'h0};
        end else if (ea == 0 && eb == 0) begin
            rs = {sa & sb, 31'h0};
        end else if (ea == 0) begin
            rs = {sb, eb, fb};
        end else if (eb == 0) begin
            rs = av;
        end else begin
            ma = 300'({1'b1, fa}) << (ea - 8'd1);
            mb = 300'({1'b1, fb}) << (eb - 8'd1);
            if (sa == sb) begin
                mag = ma + mb;
                rsign = sa;
            end else if (ma >= mb) begin
                mag = ma - mb;
                rsign = sa;
            end else begin
                mag = mb - ma;
                rsign = sb;
            end
            if (mag != 0) begin
                p = 0;
                for (int i = 0; i < 300; i++) if (mag[i]) p = i;
                e = p - 22;
                if (e <= 0) begin
                    rs = {rsign, 31'h0};
                    rf = 3'b001;
                end else begin
                    sh = p - 23;
                    mant = 25'(mag >> sh);
                    rem = mag & ((300'd1 << sh) - 300'd1);
                    inexact = (rem != 0);
                    if (TB_RNE && sh > 0) begin
                        half = 300'd1 << (sh - 1);
                        if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
                    end
                    if (mant[24]) begin
                        mant = mant >> 1;
                        e = e + 1;
                    end
                    if (e >= 255) begin
                        rs = TB_RNE ? {rsign, 8'hFF, 23'h0} : {rsign, 8'hFE, 23'h7FFFFF};
                        rf = 3'b011;
                    end else begin
                        rs = {rsign, 8'(e), mant[22:0]};
                        rf = {2'b00, inexact};
                    end
                end
            end
        end
    endfunction

    function automatic logic [31:0] randOperand(input logic [31:0] partner);
        int          sel, t;
        logic [7:0]  e;
        logic [22:0] f;
        sel = int'($urandom_range(0, 99));
        f = 23'($urandom);
        e = 8'($urandom_range(1, 254));
        if (sel < 4) begin
            e = 8'h00;
        end else if (sel < 8) begin
            e = 8'hFF;
            if (sel < 6) f = '0;
        end else if (sel < 14) begin
            e = 8'($urandom_range(250, 254));
        end else if (sel < 30) begin
            e = partner[30:23];
            f = partner[22:0] ^ 23'($urandom_range(0, 15));
        end else if (sel < 65) begin
            t = int'(partner[30:23]) + int'($urandom_range(0, 30)) - 5;
            if (t < 1) t = 1;
            if (t > 254) t = 254;
            e = 8'(t);
        end
        return {1'($urandom), e, f};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat, hold it until accepted (bounded), and queue the
    // result it must produce.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic mv, input logic [31:0] es,
                                 input logic [2:0] ef);
        bit accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.mode = mv;
        for (int t = 0; t < 100 && !accepted; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                expQueue.push_back('{es, ef});
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyModelled(input logic [31:0] av, input logic [31:0] bv, input logic mv);
        logic [31:0] es;
        logic [2:0]  ef;
        modelAddSub(av, bv, mv, es, ef);
        applyStimulus(av, bv, mv, es, ef);
    endtask

    task automatic drainQueue();
        for (int t = 0; t < 60 && expQueue.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_empty", 32'(expQueue.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid output must match the oldest outstanding
    // beat, and must keep matching it while stalled.
    always @(negedge clk) begin
        if (monitorOn && !rst) begin
            if (bus.out_valid) begin
                if (expQueue.size() == 0) begin
                    checkOutput("spurious_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput("sum", bus.sum, expQueue[0].sum);
                    checkOutput("flags", 32'(bus.flags), 32'(expQueue[0].flags));
                    if (bus.out_ready) void'(expQueue.pop_front());
                end
            end
            if (bus.out_ready) checkOutput("in_ready_open", 32'(bus.in_ready), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        bit seen;
        logic [31:0] opA, opB;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        waitCycles(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_sum", bus.sum, 32'd0);
        checkOutput("reset_flags", 32'(bus.flags), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        monitorOn = 1'b1;

        // Directed cases with latency measurement on the first
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        lat = 0;
        seen = 1'b0;
        for (int t = 1; t <= 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                lat = t;
            end
        end
        checkOutput("latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        applyStimulus(32'h3F800000, 32'h33C00000, 1'b0,
                      TB_RNE ? 32'h3F800001 : 32'h3F800000, 3'b001);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
                      TB_RNE ? 32'h7F800000 : 32'h7F7FFFFF, 3'b011);
        drainQueue();

        // Backpressure: six beats, out_ready low for cycles 4..8
        fork
            begin
                for (int i = 0; i < 6; i++)
                    applyModelled(32'h3F800000 + (32'(i) << 20), 32'h40000000 + 32'(i * 3),
                                  1'(i));
            end
            begin
                waitCycles(4);
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drainQueue();

        // Reset with three beats in flight
        applyModelled(32'h40A00000, 32'h3F000000, 1'b0);
        applyModelled(32'hC1200000, 32'h41200000, 1'b1);
        applyModelled(32'h42C80000, 32'h3DCCCCCD, 1'b0);
        rst = 1'b1;
        expQueue.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_sum", bus.sum, 32'd0);
        checkOutput("rst_flags", 32'(bus.flags), 32'd0);
        @(posedge clk);
        #1;
        waitCycles(8);
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        drainQueue();

        // Randomized stream with random downstream backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    opA = randOperand(32'($urandom));
                    opB = randOperand(opA);
                    applyModelled(opA, opB, 1'($urandom));
                    if ($urandom_range(0, 3) == 0) waitCycles(1);
                end
                randomDone = 1'b1;
            end
            begin
                while (!randomDone) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drainQueue();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Pipelined, parametrised floating-point adder/subtractor for the FPU datapath: computes a ± b on IEEE-754-style operands of configurable exponent/mantissa width with round-to-nearest-even, full special-value handling and exception flags. It is the successor to the single-cycle combinational adder. It sits between the FPU operand issue logic and the result writeback arbiter, using a valid/ready handshake on both sides. It sustains one operation per cycle.

## Interface
- WIDTH, 32: total operand width; must equal 1+EXP_WIDTH+MAN_WIDTH.
- EXP_WIDTH, 8: exponent field width (≥3); bias = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23: stored fraction width (≥4).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A {sign, exp, frac}.
- b  in  WIDTH  operand B.
- mode  in  1  0 = a+b, 1 = a−b (flips b sign).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  rounded result.
- flags  out  3  {invalid, overflow, inexact} for the result on sum.

## Operation
- Three stages, S1 → S2 → S3, each with a valid bit.
- S1 handles unpack/align:
  - Classify zero (exp=0, so subnormals are treated as zero; DAZ), inf, and NaN (exp all-ones, frac≠0).
  - Take the effective b sign as b_sign^mode.
  - Swap so the larger magnitude (compare exp, then frac) is the big operand.
  - Right-shift the small significand {1,frac} by the exponent difference into MAN_WIDTH+3 bits (guard, round, sticky); the sticky bit ORs all shifted-out bits.
  - A shift ≥ MAN_WIDTH+3 leaves only sticky.
- S2 performs add/sub:
  - Effective subtract = sign_a ^ sign_b_eff.
  - Form the MAN_WIDTH+4-bit sum or difference (big − small is never negative).
  - The result sign is the big operand's sign.
- S3 normalises, rounds and packs:
  - Carry-out: shift right 1, exp+1, and fold the lost bit into sticky.
  - Otherwise, leading-zero count and left shift; exp decreases by the count.
  - Round per Configuration; rounding carry-out renormalises with exp+1.
  - Exact zero difference gives +0.
  - If exp ≤ 0 after normalise, flush to signed zero and set inexact.
  - If exp ≥ all-ones, handle as overflow.
- Special cases are resolved in S1 and carried as an override through S2/S3:
  - Any NaN, or inf − inf (effective subtract of opposite infinities), gives canonical qNaN {0, all-ones, 1, 0…0} with invalid=1.
  - One infinity gives that infinity with its effective sign, flags 0.
  - Both zero: sign = sign_a & sign_b_eff.
  - One zero: the other operand passes unchanged (after DAZ).
- Flag meanings:
  - overflow is set when the rounded exp ≥ all-ones.
  - inexact is set when any of guard/round/sticky is nonzero, or on flush/overflow.
  - invalid is set only for NaN results as above.

## Timing
- Latency is exactly 3 cycles from an accepted beat (in_valid & in_ready) to out_valid, with no stall.
- Global stall: adv = ~out_valid | out_ready; in_ready = adv.
- When adv=1, all stages shift and S1 loads (in_valid & in_ready).
- When adv=0, all stage registers, sum, flags and out_valid hold.
- sum/flags are stable while out_valid & ~out_ready.
- Bubbles propagate as valid=0; a beat is never duplicated or dropped.
- in_ready is combinational from out_valid/out_ready only, never from in_valid.
- Reset values: all stage valids 0, out_valid 0, sum 0, flags 0. in_ready is 1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats; no result emerges for them.
- Throughput: 1 op/cycle while out_ready=1.

## Configuration
- FPU_ADDSUB_RNE_EN defined selects round-to-nearest-even:
  - Increment when G & (R|S|LSB).
  - Overflow gives ±inf.
- FPU_ADDSUB_RNE_EN undefined selects round-toward-zero (truncate):
  - Overflow gives ±max finite {sign, all-ones−1, all-ones frac}; overflow and inexact flags are still set.
- Flags, latency and handshake are identical in both builds.

## Test plan
- 0x3F800000 + 0x3F800000, mode=0, out_ready=1 -> sum 0x40000000, flags 000, out_valid exactly 3 cycles after accept.
- 0x3F800000 − 0x3F800000 (mode=1) -> 0x00000000 flags 000. Then 0x7F800000 + 0xFF800000 -> 0x7FC00000 flags 100.
- 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 inexact=1. 0x3F800000 + 0x33C00000 -> 0x3F800001 with FPU_ADDSUB_RNE_EN, 0x3F800000 without; both inexact=1.
- 0x7F7FFFFF + 0x7F7FFFFF -> with macro 0x7F800000 flags 011; without macro 0x7F7FFFFF flags 011.
- Backpressure: stream 6 distinct beats with out_ready low for cycles 4–8 -> in_ready follows adv, outputs hold stable while stalled, all 6 results in order, no loss or duplicate.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0 next cycle, sum=0, flags=0, no stale result afterwards; a new beat 0x40400000 − 0x3F800000 -> 0x40000000.
